fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised hazard/forwarding scoreboard for the pipelined RISC-V core. It tracks every in-flight register write in a shift-register scoreboard of configurable depth and resolves bypass sources for a configurable number of source operands. It also generates load-use stalls for a configurable load latency and squashes younger entries on a redirect flush. It sits between decode (ID) and the EX operand muxes, and replaces fixed two-source, two-stage forwarding logic.

## Interface
- STAGES, 3: tracked stages after ID; index 0 = EX, 1 = MEM, 2 = WB, …
- NUM_SRC, 2: source operands per instruction (3 for fused/FP forms).
- REG_BITS, 5: register index width.
- LOAD_LAT, 1: stages after EX before load data is forwardable. Load at stage j is forwardable iff j ≥ LOAD_LAT+1. Legal range 0..STAGES-2.
- FLUSH_STAGES, 1: number of youngest scoreboard entries (indices 0..FLUSH_STAGES-1, pre-shift) squashed by flush, in addition to the ID instruction.
- Derived: SEL_W = $clog2(STAGES+1); CNT_W = $clog2(STAGES+1).

- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rd  in  REG_BITS  destination register.
- id_wen  in  1  instruction writes id_rd.
- id_is_load  in  1  result comes from dmem.
- id_src  in  NUM_SRC*REG_BITS  source indices; operand s at bits [s*REG_BITS +: REG_BITS].
- id_src_use  in  NUM_SRC  operand s is actually read.
- flush  in  1  redirect (mispredict/jump) this cycle.
- stall  out  1  hold PC/IF/ID; a bubble enters EX.
- fwd_sel  out  NUM_SRC*SEL_W  registered per-operand select for the instruction now in EX. 0 = register file; j (1..STAGES-1) = bypass from stage j.
- ex_valid  out  1  the EX entry is a real instruction.
- inflight_cnt  out  CNT_W  number of valid writing entries (wen=1, rd≠0) in the scoreboard.

## Operation
- Scoreboard entry k (0..STAGES-1) holds valid, rd, wen, is_load. Entry k is the instruction in stage k.
- Match(s,k): entry k valid, wen=1, rd≠0, rd==src_s, and id_src_use[s]=1. The youngest match (smallest k) wins. x0 never matches.
- For operand s with youngest match at k, the producer will sit at stage j = k+1 when the consumer reaches EX:
  - j ≥ STAGES: select 0 (the write has retired; the regfile is write-first).
  - producer not a load: select j.
  - producer is a load and j ≥ LOAD_LAT+1: select j.
  - producer is a load and j < LOAD_LAT+1: hazard.
- stall = id_valid & !flush & (hazard on any operand). The result is combinational.
- On each clock edge (no rst):
  - Entries shift k→k+1; entry STAGES-1 is discarded.
  - If flush: pre-shift entries with k < FLUSH_STAGES are invalidated as they shift.
  - Entry 0 loads the ID instruction if id_valid & !stall & !flush; otherwise it loads a bubble (valid=0).
  - fwd_sel is registered from the selects above when the ID instruction is issued. On a bubble it is registered as 0.
  - ex_valid mirrors the new entry 0 valid.
  - inflight_cnt is recounted from the next-state entries (registered).
- Stalled instructions are re-evaluated every cycle. The stall releases exactly when the load reaches stage LOAD_LAT (pre-shift).

## Timing
- Reset: all entries invalid, fwd_sel = 0, ex_valid = 0, inflight_cnt = 0, stall = 0 (no valid entries). rst overrides flush and issue.
- Issue latency is 1 cycle from ID to entry 0 / fwd_sel.
- Load-use penalty is LOAD_LAT − k bubbles for a consumer issued while the load is at entry k (LOAD_LAT=1, back-to-back: 1 bubble).
- flush & stall in the same cycle: flush wins; stall is deasserted and the ID instruction is squashed.
- Multiple sources matching different stages resolve independently. Each takes its own youngest match.
- Back-to-back writers to the same rd: the younger one shadows the older.
- A valid non-writing entry (wen=0) or rd=0 never affects stall, fwd_sel, or inflight_cnt.

## Test plan
- ALU chain, default params: `add x5` then `add x6,x5,x5` next cycle → fwd_sel op0 = op1 = 1, no stall. An independent instruction between the two → select 2. Two independent instructions between → select 0.
- Load-use, LOAD_LAT=1: `lw x7` then `add x8,x7,x0` → stall high 1 cycle, ex_valid = 0 for that cycle, then the add issues with fwd_sel op0 = 2.
- LOAD_LAT=2, STAGES=4: `lw x9` followed immediately by a consumer → 2 stall cycles, then select 3.
- Flush priority: flush asserted while a stall is pending → stall = 0. Next cycle ex_valid = 0 and entry 0 is squashed; inflight_cnt drops accordingly.
- Shadowing plus x0, NUM_SRC=3: writers `x4←A`, `x4←B`, then a consumer with srcs (x4, x0, x4) → op0 = op2 = 1, op1 = 0.
- Reset mid-operation: rst asserted with 3 valid entries and stall high → next cycle all outputs are 0 and a fresh consumer of the old rd gets select 0.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for the forwarding scoreboard: ID operands in,
// stall/bypass selects out.
interface fwd_scoreboard_if #(
    parameter int STAGES   = 3,
    parameter int NUM_SRC  = 2,
    parameter int REG_BITS = 5
);
    localparam int SEL_W = $clog2(STAGES + 1);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic                        id_valid;
    logic [REG_BITS-1:0]         id_rd;
    logic                        id_wen;
    logic                        id_is_load;
    logic [NUM_SRC*REG_BITS-1:0] id_src;
    logic [NUM_SRC-1:0]          id_src_use;
    logic                        flush;
    logic                        stall;
    logic [NUM_SRC*SEL_W-1:0]    fwd_sel;
    logic                        ex_valid;
    logic [CNT_W-1:0]            inflight_cnt;

    modport master (
        output id_valid, id_rd, id_wen, id_is_load,
        output id_src, id_src_use, flush,
        input  stall, fwd_sel, ex_valid, inflight_cnt
    );

    modport slave (
        input  id_valid, id_rd, id_wen, id_is_load,
        input  id_src, id_src_use, flush,
        output stall, fwd_sel, ex_valid, inflight_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register hazard scoreboard: resolves bypass selects per operand,
// raises load-use stalls and squashes young entries on redirect.
module fwd_scoreboard #(
    parameter int STAGES       = 3,
    parameter int NUM_SRC      = 2,
    parameter int REG_BITS     = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_STAGES = 1
) (
    input logic            clk,
    input logic            rst,
    fwd_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(STAGES + 1);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]                vld_q, vld_d;
    logic [STAGES-1:0]                wen_q, wen_d;
    logic [STAGES-1:0]                ld_q, ld_d;
    logic [STAGES-1:0][REG_BITS-1:0]  rd_q, rd_d;
    logic [NUM_SRC*SEL_W-1:0]         fwd_sel_q, fwd_sel_d;
    logic                             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;

    logic [NUM_SRC*SEL_W-1:0]         sel;
    logic [NUM_SRC-1:0]               haz;
    logic [REG_BITS-1:0]              src;
    logic                             stall;
    logic                             issue;

    // Scan oldest to youngest so the youngest matching writer wins.
    always_comb begin
        sel = '0;
        haz = '0;
        src = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src = bus.id_src[s*REG_BITS +: REG_BITS];
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (vld_q[k] && wen_q[k] && rd_q[k] != '0 &&
                    rd_q[k] == src && bus.id_src_use[s]) begin
                    if (k + 1 >= STAGES) begin
                        sel[s*SEL_W +: SEL_W] = '0;
                        haz[s] = 1'b0;
                    end else begin
                        sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        haz[s] = ld_q[k] && (k + 1 < LOAD_LAT + 1);
                    end
                end
            end
        end
    end

    assign stall = bus.id_valid & ~bus.flush & (|haz);
    assign issue = bus.id_valid & ~bus.flush & ~(|haz);

    always_comb begin
        vld_d = '0;
        wen_d = '0;
        ld_d  = '0;
        rd_d  = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_d[k] = vld_q[k-1] & ~(bus.flush && (k - 1 < FLUSH_STAGES));
            wen_d[k] = wen_q[k-1];
            ld_d[k]  = ld_q[k-1];
            rd_d[k]  = rd_q[k-1];
        end
        vld_d[0] = issue;
        wen_d[0] = bus.id_wen;
        ld_d[0]  = bus.id_is_load;
        rd_d[0]  = bus.id_rd;

        fwd_sel_d  = issue ? sel : '0;
        ex_valid_d = issue;

        cnt_d = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (vld_d[k] && wen_d[k] && rd_d[k] != '0)
                cnt_d = cnt_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q      <= '0;
            wen_q      <= '0;
            ld_q       <= '0;
            rd_q       <= '0;
            fwd_sel_q  <= '0;
            ex_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            vld_q      <= vld_d;
            wen_q      <= wen_d;
            ld_q       <= ld_d;
            rd_q       <= rd_d;
            fwd_sel_q  <= fwd_sel_d;
            ex_valid_q <= ex_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stall        = stall;
    assign bus.fwd_sel      = fwd_sel_q;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.inflight_cnt = cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: a 3-stage/3-operand instance and a
// 4-stage/LOAD_LAT=2 instance driven from vector records.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    fwd_scoreboard_if #(.STAGES(3), .NUM_SRC(3), .REG_BITS(5)) ba ();
    fwd_scoreboard_if #(.STAGES(4), .NUM_SRC(2), .REG_BITS(5)) bb ();

    fwd_scoreboard #(
        .STAGES(3), .NUM_SRC(3), .REG_BITS(5),
        .LOAD_LAT(1), .FLUSH_STAGES(1)
    ) dut_a (
        .clk(clk), .rst(rst_a), .bus(ba.slave)
    );

    fwd_scoreboard #(
        .STAGES(4), .NUM_SRC(2), .REG_BITS(5),
        .LOAD_LAT(2), .FLUSH_STAGES(1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bb.slave)
    );

    typedef struct {
        logic        dut;
        logic        rst;
        logic        vld;
        logic        wen;
        logic        ld;
        logic        fl;
        logic [4:0]  rd;
        logic [14:0] src;
        logic [2:0]  su;
        logic        e_stall;
        logic        e_exv;
        logic [5:0]  e_sel;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct packed {
        logic       exv;
        logic [5:0] sel;
        logic [2:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    vec_t tab[19];

    function automatic logic [14:0] s3(input int a, input int b, input int c);
        return {c[4:0], b[4:0], a[4:0]};
    endfunction

    function automatic vec_t mk(
        input logic d, input logic r, input logic v,
        input logic w, input logic l, input logic f,
        input int rd, input logic [14:0] src, input logic [2:0] su,
        input logic es, input logic ee,
        input logic [5:0] esel, input int ecnt
    );
        vec_t x;
        x.dut = d; x.rst = r; x.vld = v;
        x.wen = w; x.ld = l; x.fl = f;
        x.rd = rd[4:0]; x.src = src; x.su = su;
        x.e_stall = es; x.e_exv = ee;
        x.e_sel = esel; x.e_cnt = ecnt[2:0];
        return x;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0h want %0h",
                     nm, vec_no, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        if (!v.dut) begin
            rst_a         = v.rst;
            ba.id_valid   = v.vld;
            ba.id_wen     = v.wen;
            ba.id_is_load = v.ld;
            ba.flush      = v.fl;
            ba.id_rd      = v.rd;
            ba.id_src     = v.src;
            ba.id_src_use = v.su;
        end else begin
            rst_b         = v.rst;
            bb.id_valid   = v.vld;
            bb.id_wen     = v.wen;
            bb.id_is_load = v.ld;
            bb.flush      = v.fl;
            bb.id_rd      = v.rd;
            bb.id_src     = v.src[9:0];
            bb.id_src_use = v.su[1:0];
        end
    endtask

    task automatic read_out(input logic d, output logic stl,
                            output logic exv, output logic [5:0] sel,
                            output logic [2:0] cnt);
        if (!d) begin
            stl = ba.stall;
            exv = ba.ex_valid;
            sel = ba.fwd_sel;
            cnt = {1'b0, ba.inflight_cnt};
        end else begin
            stl = bb.stall;
            exv = bb.ex_valid;
            sel = bb.fwd_sel;
            cnt = bb.inflight_cnt;
        end
    endtask

    task automatic step(input vec_t v);
        logic       stl;
        logic       exv;
        logic [5:0] sel;
        logic [2:0] cnt;
        exp_t       e;
        @(negedge clk);
        drive(v);
        #1;
        read_out(v.dut, stl, exv, sel, cnt);
        chk("stall", {7'd0, stl}, {7'd0, v.e_stall});
        q.push_back('{exv: v.e_exv, sel: v.e_sel, cnt: v.e_cnt});
        @(posedge clk);
        #1;
        read_out(v.dut, stl, exv, sel, cnt);
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty vec %0d got 0 want 1", vec_no);
        end else begin
            e = q.pop_front();
            chk("ex_valid", {7'd0, exv}, {7'd0, e.exv});
            chk("fwd_sel", {2'd0, sel}, {2'd0, e.sel});
            chk("inflight_cnt", {5'd0, cnt}, {5'd0, e.cnt});
        end
        vec_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ba.id_valid = 0; ba.id_wen = 0; ba.id_is_load = 0;
        ba.flush = 0; ba.id_rd = '0; ba.id_src = '0;
        ba.id_src_use = '0;
        bb.id_valid = 0; bb.id_wen = 0; bb.id_is_load = 0;
        bb.flush = 0; bb.id_rd = '0; bb.id_src = '0;
        bb.id_src_use = '0;

        // d rst v w l f rd src use | stall exv sel cnt
        tab[0]  = mk(0,1,0,0,0,0, 0, s3(0,0,0), 3'b000,
                     0,0,6'b000000,0);
        tab[1]  = mk(0,0,1,1,0,0, 5, s3(1,2,0), 3'b011,
                     0,1,6'b000000,1);
        tab[2]  = mk(0,0,1,1,0,0, 6, s3(5,5,0), 3'b011,
                     0,1,6'b000101,2);
        tab[3]  = mk(0,0,1,1,0,0, 10, s3(1,2,0), 3'b011,
                     0,1,6'b000000,3);
        tab[4]  = mk(0,0,1,0,0,0, 0, s3(6,6,0), 3'b011,
                     0,1,6'b001010,2);
        tab[5]  = mk(0,0,1,0,0,0, 0, s3(6,10,0), 3'b001,
                     0,1,6'b000000,1);
        tab[6]  = mk(0,0,0,0,0,0, 0, s3(0,0,0), 3'b000,
                     0,0,6'b000000,0);
        tab[7]  = mk(0,0,1,1,1,0, 7, s3(1,0,0), 3'b001,
                     0,1,6'b000000,1);
        tab[8]  = mk(0,0,1,1,0,0, 8, s3(7,0,0), 3'b011,
                     1,0,6'b000000,1);
        tab[9]  = mk(0,0,1,1,0,0, 8, s3(7,0,0), 3'b011,
                     0,1,6'b000010,2);
        tab[10] = mk(0,0,1,1,1,0, 11, s3(1,0,0), 3'b001,
                     0,1,6'b000000,2);
        tab[11] = mk(0,0,1,1,0,1, 12, s3(11,0,0), 3'b001,
                     0,0,6'b000000,1);
        tab[12] = mk(0,0,1,1,0,0, 12, s3(11,0,0), 3'b001,
                     0,1,6'b000000,1);
        tab[13] = mk(0,0,1,1,0,0, 4, s3(1,0,0), 3'b001,
                     0,1,6'b000000,2);
        tab[14] = mk(0,0,1,1,0,0, 4, s3(1,0,0), 3'b000,
                     0,1,6'b000000,3);
        tab[15] = mk(0,0,1,0,0,0, 0, s3(4,0,4), 3'b111,
                     0,1,6'b010001,2);
        tab[16] = mk(0,0,1,1,1,0, 13, s3(0,0,0), 3'b000,
                     0,1,6'b000000,2);
        tab[17] = mk(0,1,1,0,0,0, 0, s3(13,0,0), 3'b001,
                     1,0,6'b000000,0);
        tab[18] = mk(0,0,1,0,0,0, 0, s3(13,4,0), 3'b011,
                     0,1,6'b000000,0);

        for (int i = 0; i < 19; i++)
            step(tab[i]);

        // Two-bubble load-use on the deeper pipe, then select 3.
        step(mk(1,1,0,0,0,0, 0, s3(0,0,0), 3'b000,
                0,0,6'b000000,0));
        step(mk(1,0,1,1,1,0, 9, s3(0,0,0), 3'b000,
                0,1,6'b000000,1));
        step(mk(1,0,1,1,0,0, 14, s3(9,0,0), 3'b001,
                1,0,6'b000000,1));
        step(mk(1,0,1,1,0,0, 14, s3(9,0,0), 3'b001,
                1,0,6'b000000,1));
        step(mk(1,0,1,1,0,0, 14, s3(9,0,0), 3'b001,
                0,1,6'b000011,2));
        step(mk(1,0,1,0,0,0, 0, s3(9,14,0), 3'b011,
                0,1,6'b001000,1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
